// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: FSM states, opcode constants and instruction field positions for alu_sequencer
package alu_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_HALT} state_t;
    localparam logic [2:0] OP_LOAD = 3'd6;
    localparam logic [2:0] OP_SYS  = 3'd7;
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int SRC_BIT = 4;
    localparam int IMM_MSB = 3;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: instruction class flags from the IR op/src fields (BZ only with ALU_SEQ_BRANCH_EN)
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_src,
    output logic       o_is_alu,
    output logic       o_is_load,
    output logic       o_is_mov,
    output logic       o_is_halt,
    output logic       o_is_bz,
    output logic       o_use_b
);
    assign o_is_alu  = i_op < OP_LOAD;
`ifdef ALU_SEQ_BRANCH_EN
    assign o_is_bz   = (i_op == OP_LOAD) && i_src;
`else
    assign o_is_bz   = 1'b0;
`endif
    assign o_is_load = (i_op == OP_LOAD) && !o_is_bz;
    assign o_is_mov  = (i_op == OP_SYS) && !i_src;
    assign o_is_halt = (i_op == OP_SYS) && i_src;
    assign o_use_b   = i_src;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute controller for the clocked 4-bit ALU; ALU_SEQ_BRANCH_EN adds BZ and a Z flag
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W        = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_ack,
    input  logic [7:0]      instr_data,
    output logic            alu_en,
    output logic [2:0]      alu_opcode,
    output logic [3:0]      alu_in_1,
    output logic [3:0]      alu_in_2,
    input  logic [3:0]      alu_out,
    output logic [3:0]      acc_out,
    output logic            busy,
    output logic            halted
);
    localparam int CW = (ALU_LATENCY > 2) ? $clog2(ALU_LATENCY - 1) : 1;
    state_t          r_state, w_next;
    logic [PC_W-1:0] r_pc;
    logic [3:0]      r_a, r_b;
    logic [7:0]      r_ir;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      w_imm;
    logic            w_is_alu, w_is_load, w_is_mov, w_is_halt, w_is_bz, w_use_b, w_z;
    assign w_imm = r_ir[IMM_MSB:0];
    alu_seq_decode u_dec (
        .i_op      (r_ir[OP_MSB:OP_LSB]),
        .i_src     (r_ir[SRC_BIT]),
        .o_is_alu  (w_is_alu),
        .o_is_load (w_is_load),
        .o_is_mov  (w_is_mov),
        .o_is_halt (w_is_halt),
        .o_is_bz   (w_is_bz),
        .o_use_b   (w_use_b)
    );
`ifdef ALU_SEQ_BRANCH_EN
    logic r_z;
    // Z follows the last ALU result written back; LOAD/MOV/BZ leave it alone
    always_ff @(posedge clk)
        if (rst) r_z <= 1'b0;
        else if (ena && r_state == S_WB && w_is_alu) r_z <= (alu_out == 4'd0);
    assign w_z = r_z;
`else
    assign w_z = 1'b0;
`endif
    // State register; ena low freezes the FSM so an EXEC cycle is reissued later
    always_ff @(posedge clk)
        if (rst) r_state <= S_IDLE;
        else if (ena) r_state <= w_next;
    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: w_next = start ? S_FETCH : r_state;
            S_FETCH:  w_next = instr_ack ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_is_alu ? S_EXEC : (w_is_halt ? S_HALT : S_WB);
            S_EXEC:   w_next = (ALU_LATENCY > 1) ? S_WAIT : S_WB;
            S_WAIT:   w_next = (r_cnt == CW'(ALU_LATENCY - 2)) ? S_WB : S_WAIT;
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end
    // PC, IR, WAIT counter and A/B write-back
    always_ff @(posedge clk)
        if (rst) begin
            r_pc  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_ir  <= '0;
            r_cnt <= '0;
        end else if (ena) begin
            if ((r_state == S_IDLE || r_state == S_HALT) && start) r_pc <= '0;
            if (r_state == S_FETCH && instr_ack) r_ir <= instr_data;
            r_cnt <= (r_state == S_WAIT) ? r_cnt + CW'(1) : '0;
            if (r_state == S_WB) begin
                r_pc <= (w_is_bz && w_z) ? w_imm[PC_W-1:0] : r_pc + PC_W'(1);
                r_a  <= w_is_alu ? alu_out : (w_is_load ? w_imm : r_a);
                r_b  <= w_is_mov ? r_a : r_b;
            end
        end
    assign instr_req  = r_state == S_FETCH;
    assign instr_addr = r_pc;
    assign alu_en     = ena && r_state == S_EXEC;
    assign alu_opcode = r_ir[OP_MSB:OP_LSB];
    assign alu_in_1   = r_a;
    assign alu_in_2   = w_use_b ? r_b : w_imm;
    assign acc_out    = r_a;
    assign busy       = !(r_state == S_IDLE || r_state == S_HALT);
    assign halted     = r_state == S_HALT;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized bench for alu_sequencer against an instruction-level model
module tb_alu_sequencer;
    localparam int PC_W = 4;
`ifdef ALU_SEQ_BRANCH_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1, ena = 1'b1, start = 1'b0, instr_ack = 1'b0;
    logic [7:0] instr_data = 8'h00;
    logic instr_req, alu_en, busy, halted;
    logic [PC_W-1:0] instr_addr;
    logic [2:0] alu_opcode;
    logic [3:0] alu_in_1, alu_in_2, alu_out, acc_out;
    logic [3:0] pipe [LAT];
    int tests = 0, fails = 0;
    logic [7:0] prog [16];
    int ack_delay = 0, req_cyc = 0, unstable = 0;
    logic [3:0] req_addr;
    int req_len_q [$];
    logic [3:0] fetch_log [$];
    logic [3:0] exp_addr [$];
    int alu_cnt = 0, alu_bad = 0;
    logic [2:0] last_op;
    logic [3:0] last_in1, last_in2;
    logic [3:0] m_a, m_b;
    logic m_z;

    alu_sequencer #(.PC_W(PC_W), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_data(instr_data),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
        .alu_out(alu_out), .acc_out(acc_out), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        case (op)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            default: return ~x;
        endcase
    endfunction

    // Stand-in ALU: result appears LAT enabled cycles after alu_en
    assign alu_out = pipe[LAT-1];
    always @(posedge clk)
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= 4'd0;
        end else if (ena) begin
            for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            if (alu_en) pipe[0] <= alu_f(alu_opcode, alu_in_1, alu_in_2);
        end

    // Instruction memory: acks after ack_delay extra cycles, checks the address holds
    always @(negedge clk)
        if (instr_req) begin
            if (req_cyc > 0 && instr_addr !== req_addr) unstable++;
            if (req_cyc == 0) req_addr = instr_addr;
            req_cyc++;
            instr_ack = (req_cyc > ack_delay);
            instr_data = prog[instr_addr];
        end else begin
            req_cyc = 0;
            instr_ack = 1'b0;
        end

    // Observe captured fetches and ALU enables
    always @(posedge clk) begin
        if (!rst && ena && instr_req && instr_ack) begin
            fetch_log.push_back(instr_addr);
            req_len_q.push_back(req_cyc);
        end
        if (alu_en) begin
            alu_cnt++;
            last_op = alu_opcode;
            last_in1 = alu_in_1;
            last_in2 = alu_in_2;
        end
        if (alu_en && !ena) alu_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; start = 1'b0; ena = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_a = 4'd0; m_b = 4'd0; m_z = 1'b0;
        unstable = 0; alu_bad = 0;
    endtask

    // ISA-level reference: executes up to n instructions from address 0
    task automatic model_run(input int n, output bit hlt);
        int pc;
        logic [7:0] ins;
        logic [3:0] opd;
        pc = 0; hlt = 1'b0;
        exp_addr.delete();
        for (int k = 0; k < n && !hlt; k++) begin
            ins = prog[pc];
            opd = ins[4] ? m_b : ins[3:0];
            exp_addr.push_back(4'(pc));
            if (ins[7:5] < 3'd6) begin
                m_a = alu_f(ins[7:5], m_a, opd);
                m_z = (m_a == 4'd0);
                pc = (pc + 1) % 16;
            end else if (ins[7:5] == 3'd6) begin
`ifdef ALU_SEQ_BRANCH_EN
                if (ins[4]) pc = m_z ? int'(ins[3:0]) : (pc + 1) % 16;
                else begin m_a = ins[3:0]; pc = (pc + 1) % 16; end
`else
                m_a = ins[3:0];
                pc = (pc + 1) % 16;
`endif
            end else if (!ins[4]) begin
                m_b = m_a;
                pc = (pc + 1) % 16;
            end else hlt = 1'b1;
        end
        if (!hlt) exp_addr.push_back(4'(pc));
    endtask

    task automatic run_check(input string name, input int n, input int budget, input bit rnd);
        bit hlt, done, ok;
        int cyc;
        model_run(n, hlt);
        fetch_log.delete(); req_len_q.delete(); alu_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0; done = 1'b0;
        while (!done && cyc < budget) begin
            if (rnd) begin
                ena = ($urandom_range(0, 3) != 0);
                start = busy && ($urandom_range(0, 7) == 0);
            end
            tick(); cyc++;
            done = halted || fetch_log.size() >= n + 1;
        end
        ena = 1'b1; start = 1'b0;
        tests++;
        if (!done) begin fails++; $display("FAIL %s_timeout got %0d fetches after %0d cycles", name, fetch_log.size(), cyc); end
        ok = (fetch_log.size() == exp_addr.size());
        if (ok) foreach (exp_addr[i]) if (fetch_log[i] !== exp_addr[i]) ok = 1'b0;
        tests++;
        if (!ok) begin fails++; $display("FAIL %s_fetch_seq got %p want %p", name, fetch_log, exp_addr); end
        tests++;
        if (acc_out !== m_a) begin fails++; $display("FAIL %s_acc got %h want %h", name, acc_out, m_a); end
        tests++;
        if (halted !== hlt) begin fails++; $display("FAIL %s_halted got %b want %b", name, halted, hlt); end
        tests++;
        if (alu_bad != 0 || unstable != 0) begin fails++; $display("FAIL %s_protocol got en_while_frozen=%0d addr_changes=%0d want 0 0", name, alu_bad, unstable); end
    endtask

    task automatic test_reset();
        start = 1'b1;
        reset_dut();
        tests++;
        if ({instr_req, instr_addr} !== 5'd0) begin fails++; $display("FAIL reset_fetch got %h want 0", {instr_req, instr_addr}); end
        tests++;
        if ({alu_en, alu_opcode, alu_in_1, alu_in_2} !== 12'd0) begin fails++; $display("FAIL reset_alu got %h want 0", {alu_en, alu_opcode, alu_in_1, alu_in_2}); end
        tests++;
        if ({acc_out, busy, halted} !== 6'd0) begin fails++; $display("FAIL reset_status got %h want 0", {acc_out, busy, halted}); end
    endtask

    task automatic test_spec_prog();
        foreach (prog[i]) prog[i] = 8'hF0;
        prog[0] = 8'hC5; prog[1] = 8'hE0; prog[2] = 8'hC3; prog[3] = 8'h10;
        reset_dut();
        run_check("spec", 20, 200, 1'b0);
        tests++;
        if (alu_cnt != 1) begin fails++; $display("FAIL spec_alu_en_count got %0d want 1", alu_cnt); end
        tests++;
        if ({last_op, last_in1, last_in2} !== {3'd0, 4'd3, 4'd5}) begin fails++; $display("FAIL spec_operands got %h want %h", {last_op, last_in1, last_in2}, {3'd0, 4'd3, 4'd5}); end
        tests++;
        if (acc_out !== alu_f(3'd0, 4'd3, 4'd5)) begin fails++; $display("FAIL spec_result got %h want %h", acc_out, alu_f(3'd0, 4'd3, 4'd5)); end
        tests++;
        if (instr_addr !== 4'd4) begin fails++; $display("FAIL spec_halt_pc got %h want 4", instr_addr); end
    endtask

    task automatic test_halt();
        foreach (prog[i]) prog[i] = 8'hF0;
        reset_dut();
        run_check("halt", 4, 100, 1'b0);
        tests++;
        if ({busy, instr_addr} !== 5'd0 || alu_cnt != 0) begin fails++; $display("FAIL halt_state got busy=%b pc=%h alu_en=%0d want 0 0 0", busy, instr_addr, alu_cnt); end
        run_check("restart", 4, 100, 1'b0);
    endtask

    task automatic test_ack_delay();
        foreach (prog[i]) prog[i] = 8'hF0;
        prog[0] = 8'hC7;
        ack_delay = 3;
        reset_dut();
        run_check("ack_delay", 20, 200, 1'b0);
        tests++;
        if (req_len_q.size() != 2 || req_len_q[0] != 4) begin fails++; $display("FAIL ack_delay_req_len got %p want two captures, first after 4", req_len_q); end
        ack_delay = 0;
    endtask

    task automatic test_ena_exec();
        logic [2:0] op;
        int cyc;
        bit bad;
        op = 3'($urandom_range(0, 5));
        foreach (prog[i]) prog[i] = 8'hF0;
        prog[0] = 8'hC5; prog[1] = 8'hE0; prog[2] = 8'hC3; prog[3] = {op, 1'b1, 4'h0};
        reset_dut();
        alu_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!alu_en && cyc < 50) begin tick(); cyc++; end
        tests++;
        if (alu_en !== 1'b1) begin fails++; $display("FAIL ena_reach_exec got alu_en=%b want 1", alu_en); end
        ena = 1'b0; bad = 1'b0;
        repeat (5) begin tick(); if (alu_en !== 1'b0 || busy !== 1'b1) bad = 1'b1; end
        tests++;
        if (bad) begin fails++; $display("FAIL ena_frozen got alu_en/busy change want alu_en=0 busy=1"); end
        ena = 1'b1;
        cyc = 0;
        while (!halted && cyc < 50) begin tick(); cyc++; end
        tests++;
        if (alu_cnt != 1) begin fails++; $display("FAIL ena_alu_en_count got %0d want 1", alu_cnt); end
        tests++;
        if (acc_out !== alu_f(op, 4'd3, 4'd5)) begin fails++; $display("FAIL ena_result got %h want %h", acc_out, alu_f(op, 4'd3, 4'd5)); end
    endtask

    task automatic test_wrap();
        foreach (prog[i]) prog[i] = 8'hC0 | 8'(i);
        reset_dut();
        run_check("wrap", 16, 400, 1'b0);
        tests++;
        if (fetch_log.size() != 17 || fetch_log[15] !== 4'd15 || fetch_log[16] !== 4'd0) begin fails++; $display("FAIL wrap_addr got %p want 0..15 then 0", fetch_log); end
    endtask

    task automatic test_rst_mid();
        foreach (prog[i]) prog[i] = 8'hC1;
        ack_delay = 8;
        reset_dut();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tests++;
        if ({instr_req, instr_addr, alu_en, acc_out, busy, halted} !== 12'd0) begin fails++; $display("FAIL rst_mid_fetch got %h want 0", {instr_req, instr_addr, alu_en, acc_out, busy, halted}); end
        ack_delay = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            foreach (prog[i]) prog[i] = 8'($urandom);
            ack_delay = $urandom_range(0, 2);
            reset_dut();
            run_check($sformatf("random%0d", it), 24, 1000, 1'b1);
        end
        ack_delay = 0;
    endtask

`ifdef ALU_SEQ_BRANCH_EN
    task automatic test_branch();
        int cyc;
        foreach (prog[i]) prog[i] = 8'hF0;
        prog[0] = 8'hC3; prog[1] = 8'h23; prog[2] = 8'hD9;
        reset_dut();
        run_check("bz_taken", 20, 200, 1'b0);
        tests++;
        if (fetch_log.size() < 4 || fetch_log[3] !== 4'd9) begin fails++; $display("FAIL bz_taken_addr got %p want 0 1 2 9", fetch_log); end
        prog[1] = 8'h01;
        reset_dut();
        run_check("bz_not_taken", 20, 200, 1'b0);
        tests++;
        if (fetch_log.size() < 4 || fetch_log[3] !== 4'd3) begin fails++; $display("FAIL bz_not_taken_addr got %p want 0 1 2 3", fetch_log); end
        reset_dut();
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!alu_en && cyc < 50) begin tick(); cyc++; end
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tests++;
        if ({instr_req, instr_addr, alu_en, alu_opcode, alu_in_1, alu_in_2, acc_out, busy, halted} !== 22'd0) begin fails++; $display("FAIL rst_mid_wait got %h want 0", {instr_req, instr_addr, alu_en, alu_opcode, alu_in_1, alu_in_2, acc_out, busy, halted}); end
    endtask
`endif

    initial begin
        test_reset();
        test_spec_prog();
        test_halt();
        test_ack_delay();
        test_ena_exec();
        test_wrap();
        test_rst_mid();
        test_random();
`ifdef ALU_SEQ_BRANCH_EN
        test_branch();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
